// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_e : receive FSM state encoding
//   DATA_BITS       : payload bits per frame
//   BAUD_DEFAULT    : default sys_clk cycles per bit (200 MHz / 115200)
//   even_parity()   : parity bit that makes the total count of ones even
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int BAUD_DEFAULT = 1736;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial line plus received-byte bundle between the UART
// receiver and the command decoder.
//   rx         : raw asynchronous serial line, idle high
//   rx_data    : last good byte, LSB received first
//   rx_valid   : one-cycle strobe, rx_data updated
//   frame_err  : one-cycle strobe, stop bit sampled low
//   parity_err : one-cycle strobe, parity mismatch
//   rx_busy    : receiver is inside a frame
// Modports: master = receiver side, slave = line driver / byte consumer.
interface uart_rx_ctrl_if;

    logic                           rx;
    logic [uart_pkg::DATA_BITS-1:0] rx_data;
    logic                           rx_valid;
    logic                           frame_err;
    logic                           parity_err;
    logic                           rx_busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, frame_err, parity_err, rx_busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, frame_err, parity_err, rx_busy
    );

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: restartable down-counter used to place bit samples.
//   sys_clk  : system clock
//   rst_n    : asynchronous active-low reset
//   load     : restart the period with load_val (wins over counting)
//   load_val : period length N in cycles
//   done     : high exactly N cycles after the load cycle
module uart_bit_timer #(
    parameter  int MAX = 1736,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // Decoding 1 rather than 0 makes the period exactly N cycles: the value
    // loaded at the end of the load cycle reaches 1 after N-1 decrements.
    assign done = (count_reg == W'(1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller for the RGB-PWM command path.
// Synchronises rx, re-aligns the bit timer to the start-bit falling edge,
// samples every bit at mid-period, checks the stop bit and delivers one byte
// per good frame as a single-cycle strobe.
//   sys_clk : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : uart_rx_ctrl_if.master (rx in; rx_data, rx_valid, frame_err,
//             parity_err, rx_busy out)
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a live
// parity_err; otherwise frames are 8N1 and parity_err is tied low.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DEFAULT
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    uart_rx_ctrl_if.master bus
);

    localparam int            TW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);

    // Two-flop synchroniser, idle-high reset so no false start after reset.
    logic rx_meta_reg, rx_s_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    uart_rx_state_e       state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic                 valid_reg, valid_next;
    logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_reg, par_bad_next;
    logic                 par_err_reg, par_err_next;
`endif

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    uart_bit_timer #(.MAX(CLKS_PER_BIT)) u_timer (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            data_reg      <= '0;
            bit_idx_reg   <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            bit_idx_reg   <= bit_idx_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg   <= par_bad_next;
            par_err_reg   <= par_err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        bit_idx_next   = bit_idx_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        timer_load     = 1'b0;
        timer_val      = FULL;
`ifdef UART_RX_PARITY_EN
        par_bad_next   = par_bad_reg;
        par_err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                // Half-period load lands the next sample mid start bit.
                if (!rx_s_reg) begin
                    timer_load = 1'b1;
                    timer_val  = HALF;
                    state_next = START;
                end
            end
            START: begin
                if (timer_done) begin
                    if (!rx_s_reg) begin
                        timer_load   = 1'b1;
                        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_next = 1'b0;
`endif
                        state_next   = DATA;
                    end else begin
                        // Line was high again mid start bit: a glitch.
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer_done) begin
                    shift_next[bit_idx_reg] = rx_s_reg;
                    timer_load   = 1'b1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer_done) begin
                    par_bad_next = rx_s_reg ^ even_parity(shift_reg);
                    timer_load   = 1'b1;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (timer_done) begin
                    if (rx_s_reg) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad_reg) begin
                            par_err_next = 1'b1;
                        end else begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end
`else
                        data_next  = shift_reg;
                        valid_next = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        // Framing error wins; wait out a break so it only
                        // reports once.
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.rx_busy   = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = par_err_reg;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl with
// CLKS_PER_BIT=16. Frames are 8N1 by default, 8E1 when UART_RX_PARITY_EN
// is defined for both bench and design.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 10 + PBITS;
    // Cycles from driving the start edge on the pad to the strobe cycle:
    // 2 sync + H + (9+P)*CPB to the stop sample + 1 registered output.
    localparam int STROBE_OFS = 2 + CPB / 2 + (9 + PBITS) * CPB + 1;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.master)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         perr_cnt  = 0;
    int         ferr_cyc  = -1;
    int         valid_cyc_q[$];
    logic [7:0] valid_data_q[$];

    always @(negedge sys_clk) begin
        if (bus.rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc_q.push_back(cyc);
            valid_data_q.push_back(bus.rx_data);
        end
        if (bus.frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
        if (bus.parity_err) begin
            perr_cnt <= perr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    // Called just after a rising edge; leaves the bit on the pad CPB cycles.
    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_bit);
    endtask

    int c, v0, f0, p0, qs, busy_low;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("reset_rx_data", bus.rx_data, 8'h00);
        check_eq("reset_rx_valid", bus.rx_valid, 1'b0);
        check_eq("reset_frame_err", bus.frame_err, 1'b0);
        check_eq("reset_parity_err", bus.parity_err, 1'b0);
        check_eq("reset_rx_busy", bus.rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;

        // Frame 0xA5 with exact strobe timing and rx_busy window.
        c  = cyc;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        busy_low = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(c + 2);
                check_eq("a5_busy_at_t0", bus.rx_busy, 1'b0);
                for (int n = c + 3; n < c + STROBE_OFS; n++) begin
                    wait_until(n);
                    if (!bus.rx_busy) busy_low++;
                end
                wait_until(c + STROBE_OFS);
                check_eq("a5_valid_at_strobe", bus.rx_valid, 1'b1);
                check_eq("a5_busy_after_stop", bus.rx_busy, 1'b0);
            end
        join
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("a5_busy_low_cycles", busy_low, 0);
        check_eq("a5_valid_count", valid_cnt - v0, 1);
        check_eq("a5_strobe_cycle", valid_cyc_q[valid_cyc_q.size()-1] - c, STROBE_OFS);
        check_eq("a5_rx_data", bus.rx_data, 8'hA5);
        check_eq("a5_no_frame_err", ferr_cnt - f0, 0);

        // Three-cycle low glitch on an idle line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        bus.rx = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        check_eq("glitch_no_valid", valid_cnt - v0, 0);
        check_eq("glitch_no_frame_err", ferr_cnt - f0, 0);
        check_eq("glitch_rx_data", bus.rx_data, 8'hA5);
        check_eq("glitch_busy", bus.rx_busy, 1'b0);

        // 0x3C with a low stop bit, then the line held low 40 more cycles.
        c  = cyc;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge sys_clk);
        #1;
        check_eq("break_busy_while_low", bus.rx_busy, 1'b1);
        bus.rx = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        check_eq("break_frame_err_count", ferr_cnt - f0, 1);
        check_eq("break_frame_err_cycle", ferr_cyc - c, STROBE_OFS);
        check_eq("break_no_valid", valid_cnt - v0, 0);
        check_eq("break_rx_data_kept", bus.rx_data, 8'hA5);
        check_eq("break_busy_after_high", bus.rx_busy, 1'b0);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("after_break_valid", valid_cnt - v0, 1);
        check_eq("after_break_rx_data", bus.rx_data, 8'h81);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        c  = cyc;
        v0 = valid_cnt;
        qs = valid_cyc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("b2b_valid_count", valid_cnt - v0, 2);
        if (valid_cyc_q.size() >= qs + 2) begin
            check_eq("b2b_first_cycle", valid_cyc_q[qs] - c, STROBE_OFS);
            check_eq("b2b_spacing", valid_cyc_q[qs+1] - valid_cyc_q[qs], FRAME_BITS * CPB);
            check_eq("b2b_first_data", valid_data_q[qs], 8'h00);
            check_eq("b2b_second_data", valid_data_q[qs+1], 8'hFF);
        end
        check_eq("b2b_rx_data", bus.rx_data, 8'hFF);

        // Reset in the middle of data bit 4 of 0x55.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        bus.rx = 1'b1;
        repeat (8) @(posedge sys_clk);
        #1;
        check_eq("rst_busy_before", bus.rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_rx_data", bus.rx_data, 8'h00);
        check_eq("rst_rx_busy", bus.rx_busy, 1'b0);
        check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
        check_eq("rst_frame_err", bus.frame_err, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        repeat (60) @(posedge sys_clk);
        #1;
        check_eq("rst_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h12, 1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("post_rst_valid", valid_cnt - v0, 1);
        check_eq("post_rst_rx_data", bus.rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit must be 1.
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_data(8'h07);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("par_bad_parity_err", perr_cnt - p0, 1);
        check_eq("par_bad_no_valid", valid_cnt - v0, 0);
        check_eq("par_bad_rx_data", bus.rx_data, 8'h12);
        p0 = perr_cnt;
        send_data(8'h07);
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (4) @(posedge sys_clk);
        #1;
        check_eq("par_good_valid", valid_cnt - v0, 1);
        check_eq("par_good_no_parity_err", perr_cnt - p0, 0);
        check_eq("par_good_rx_data", bus.rx_data, 8'h07);
`else
        // Parity disabled: a wrong "parity" position is just the stop bit.
        p0 = 0;
        check_eq("no_parity_err_seen", perr_cnt - p0, 0);
        check_eq("no_parity_err_level", bus.parity_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
